// File: rtl/ysyx_22041412_div_iter_if.sv
// rtl/ysyx_22041412_div_iter_if.sv - request/response handshake bundle for the iterative divider
interface ysyx_22041412_div_iter_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            div_valid;
    logic            div_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            divw;
    logic            div_signed;
    logic            div_mode;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_result;

    modport master (
        output flush, div_valid, dividend, divisor, divw, div_signed, div_mode, out_ready,
        input  div_ready, out_valid, div_result
    );

    modport slave (
        input  flush, div_valid, dividend, divisor, divw, div_signed, div_mode, out_ready,
        output div_ready, out_valid, div_result
    );
endinterface

// File: rtl/ysyx_22041412_div_iter.sv
// rtl/ysyx_22041412_div_iter.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU and W-variants
module ysyx_22041412_div_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22041412_div_iter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state, state_nxt;

    logic             ready_int;
    logic             accept;
    logic             special;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_neg;
    logic [XLEN-1:0]  q_sp, r_sp;
    logic             sa, sb;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_q, quo_q, b_q, rem_nxt, quo_nxt, q_fin, r_fin;
    logic [XLEN:0]    shifted, diff;
    logic             q_neg, r_neg, mode_q, w_q;
    logic [XLEN-1:0]  result_q;

    function automatic logic [XLEN-1:0] pick(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                             input logic mode, input logic w);
        logic [XLEN-1:0] s;
        s = mode ? r : q;
        if (w) s = {{(XLEN-32){s[31]}}, s[31:0]};
        return s;
    endfunction

    // Operand preparation: word ops are extended first so every later test works on XLEN bits.
    always_comb begin
        if (bus.divw) begin
            a_ext = {{(XLEN-32){bus.div_signed & bus.dividend[31]}}, bus.dividend[31:0]};
            b_ext = {{(XLEN-32){bus.div_signed & bus.divisor[31]}}, bus.divisor[31:0]};
            min_neg = ~XLEN'(32'h7FFF_FFFF);
        end else begin
            a_ext = bus.dividend;
            b_ext = bus.divisor;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        sa    = bus.div_signed & a_ext[XLEN-1];
        sb    = bus.div_signed & b_ext[XLEN-1];
        a_mag = sa ? -a_ext : a_ext;
        b_mag = sb ? -b_ext : b_ext;
        q_sp  = '1;
        r_sp  = a_ext;
        special = 1'b1;
        if (b_ext == '0) begin
            q_sp = '1;
            r_sp = a_ext;
        end else if (bus.div_signed && a_ext == min_neg && b_ext == '1) begin
            q_sp = a_ext;
            r_sp = '0;
        end else begin
            special = 1'b0;
        end
    end

    // One restoring step: the remainder never exceeds the divisor, so XLEN+1 bits cannot overflow.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        if (!diff[XLEN]) begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        end
        q_fin = q_neg ? -quo_nxt : quo_nxt;
        r_fin = r_neg ? -rem_nxt : rem_nxt;
    end

    assign accept = bus.div_valid & ready_int;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    always_comb begin
        ready_int     = (state == S_IDLE) & ~bus.flush & rst;
        bus.div_ready = ready_int;
        bus.out_valid = (state == S_DONE);
        bus.div_result = result_q;
    end

    // Word ops pre-shift the dividend to the top so the same MSB-first loop serves both widths.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            b_q      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            mode_q   <= 1'b0;
            w_q      <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            cnt    <= bus.divw ? CNT_W'(31) : CNT_W'(XLEN-1);
            rem_q  <= '0;
            quo_q  <= bus.divw ? (a_mag << (XLEN-32)) : a_mag;
            b_q    <= b_mag;
            q_neg  <= sa ^ sb;
            r_neg  <= sa;
            mode_q <= bus.div_mode;
            w_q    <= bus.divw;
            if (special) result_q <= pick(q_sp, r_sp, bus.div_mode, bus.divw);
        end else if (state == S_CALC && !bus.flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == '0) result_q <= pick(q_fin, r_fin, mode_q, w_q);
        end
    end
endmodule

// File: tb/tb_ysyx_22041412_div_iter.sv
// tb/tb_ysyx_22041412_div_iter.sv - directed and randomized bench for ysyx_22041412_div_iter
module tb_ysyx_22041412_div_iter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ysyx_22041412_div_iter_if #(.XLEN(64)) bus ();

    ysyx_22041412_div_iter #(.XLEN(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input bit w, input bit s, input bit m);
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] q, r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            res32 = m ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end
        if (b == 64'd0) begin
            q = '1; r = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 64'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return m ? r : q;
    endfunction

    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s);
        if (w) begin
            if (b[31:0] == 32'd0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
            return 33;
        end
        if (b == 64'd0 || (s && a == 64'h8000_0000_0000_0000 && b == '1)) return 1;
        return 65;
    endfunction

    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit w, input bit s, input bit m,
                         input logic [63:0] exp, input int hold);
        int lat;
        bit busy_ok;
        @(negedge clk);
        chk({tag, "/ready_before"}, 64'(bus.div_ready), 64'd1);
        bus.dividend = a; bus.divisor = b;
        bus.divw = w; bus.div_signed = s; bus.div_mode = m;
        bus.div_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
        bus.divw = ~w; bus.div_signed = ~s; bus.div_mode = ~m;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (bus.div_ready) busy_ok = 1'b0;
        end while (!bus.out_valid && lat < 200);
        chk({tag, "/latency"}, 64'(lat), 64'(ref_lat(a, b, w, s)));
        chk({tag, "/busy_not_ready"}, 64'(busy_ok), 64'd1);
        chk({tag, "/result"}, bus.div_result, exp);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "/held_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "/held_result"}, bus.div_result, exp);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "/valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/ready_after"}, 64'(bus.div_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a, b;
        bit          w, s, m, seen;
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.flush = 1'b0; bus.div_valid = 1'b0; bus.out_ready = 1'b0;
        bus.dividend = '0; bus.divisor = '0;
        bus.divw = 1'b0; bus.div_signed = 1'b0; bus.div_mode = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset/out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset/result", bus.div_result, 64'd0);
        chk("reset/ready", 64'(bus.div_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset/ready_out", 64'(bus.div_ready), 64'd1);

        do_op("divu_100_7",  64'd100, 64'd7, 0, 0, 0, 64'd14, 0);
        do_op("remu_100_7",  64'd100, 64'd7, 0, 0, 1, 64'd2, 10);
        do_op("div_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        do_op("rem_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("div_7_m2",    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        do_op("rem_7_m2",    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 64'd1, 0);
        do_op("divu_5_0",    64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("remu_5_0",    64'd5, 64'd0, 0, 0, 1, 64'd5, 0);
        do_op("divw_5_0",    64'd5, 64'd0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("div_ovf",     64'h8000_0000_0000_0000, '1, 0, 1, 0, 64'h8000_0000_0000_0000, 0);
        do_op("rem_ovf",     64'h8000_0000_0000_0000, '1, 0, 1, 1, 64'd0, 0);
        do_op("divw_ovf",    64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 0, 64'hFFFF_FFFF_8000_0000, 0);
        do_op("divuw_ff_1",  64'hABCD_0000_FFFF_FFFF, 64'd1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("remw_m9_4",   64'hFFFF_FFFF_FFFF_FFF7, 64'd4, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 3);

        // reset in the middle of a calculation
        @(negedge clk);
        bus.dividend = 64'd1000; bus.divisor = 64'd3;
        bus.divw = 0; bus.div_signed = 0; bus.div_mode = 0; bus.div_valid = 1'b1;
        @(posedge clk);
        #1 bus.div_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid/result", bus.div_result, 64'd0);
        chk("rst_mid/ready", 64'(bus.div_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid/ready_out", 64'(bus.div_ready), 64'd1);

        // flush at CALC cycle 20
        bus.div_valid = 1'b1; bus.dividend = 64'd100; bus.divisor = 64'd7;
        @(posedge clk);
        #1 bus.div_valid = 1'b0;
        repeat (20) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush/ready", 64'(bus.div_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush/no_valid", 64'(seen), 64'd0);

        // request coinciding with flush must be dropped
        @(negedge clk);
        bus.flush = 1'b1; bus.div_valid = 1'b1;
        bus.dividend = 64'd5; bus.divisor = 64'd0;
        #1 chk("flush_req/ready", 64'(bus.div_ready), 64'd0);
        @(posedge clk);
        #1 begin bus.flush = 1'b0; bus.div_valid = 1'b0; end
        @(negedge clk);
        chk("flush_req/no_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_req/ready", 64'(bus.div_ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = {$urandom, $urandom};
                1: b = 64'($urandom_range(0, 15));
                2: b = $urandom_range(0, 1) ? '1 : 64'd0;
                default: b = {32'd0, $urandom} >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            do_op("random", a, b, w, s, m, ref_div(a, b, w, s, m), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
